// File: rtl/axi_lite_master_bridge.sv
// Arbitrates the core's fetch and data ports onto one AXI4-Lite master.
// Only one transaction is in flight at a time. Completion is a one-cycle ack to the granted requester.
module axi_lite_master_bridge #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ARB_MODE   = 0
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic                      inst_req_i,
    input  logic [ADDR_WIDTH-1:0]     inst_addr_i,
    output logic [DATA_WIDTH-1:0]     inst_rdata_o,
    output logic                      inst_ack_o,

    input  logic                      data_req_i,
    input  logic                      data_we_i,
    input  logic [ADDR_WIDTH-1:0]     data_addr_i,
    input  logic [DATA_WIDTH/8-1:0]   data_sel_i,
    input  logic [DATA_WIDTH-1:0]     data_wdata_i,
    output logic [DATA_WIDTH-1:0]     data_rdata_o,
    output logic                      data_ack_o,
    output logic                      bus_err_o,

    output logic [ADDR_WIDTH-1:0]     m_awaddr,
    output logic                      m_awvalid,
    input  logic                      m_awready,
    output logic [DATA_WIDTH-1:0]     m_wdata,
    output logic [DATA_WIDTH/8-1:0]   m_wstrb,
    output logic                      m_wvalid,
    input  logic                      m_wready,
    input  logic [1:0]                m_bresp,
    input  logic                      m_bvalid,
    output logic                      m_bready,
    output logic [ADDR_WIDTH-1:0]     m_araddr,
    output logic                      m_arvalid,
    input  logic                      m_arready,
    input  logic [DATA_WIDTH-1:0]     m_rdata,
    input  logic [1:0]                m_rresp,
    input  logic                      m_rvalid,
    output logic                      m_rready
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        IDLE,
        RD_A,
        RD_D,
        WR_AW,
        WR_B,
        RESP
    } state_t;

    state_t                  state;
    logic                    is_data_q;
    logic                    prefer_data;
    logic                    grant_data;
    logic                    grant_inst;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [STRB_WIDTH-1:0]   strb_q;

    // prefer_data only matters in round-robin mode; fixed priority always favours data
    always_comb begin
        grant_data = data_req_i && (!inst_req_i || (ARB_MODE == 0) || prefer_data);
        grant_inst = inst_req_i && !grant_data;
    end

    assign m_awaddr = addr_q;
    assign m_araddr = addr_q;
    assign m_wdata  = wdata_q;
    assign m_wstrb  = strb_q;

    // Request payload is latched while idle, so it is frozen from the grant edge onwards
    always_ff @(posedge clk) begin
        if (state == IDLE) begin
            if (grant_data) begin
                addr_q  <= data_addr_i;
                wdata_q <= data_wdata_i;
                strb_q  <= data_sel_i;
            end else begin
                addr_q  <= inst_addr_i;
                wdata_q <= '0;
                strb_q  <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            is_data_q    <= 1'b0;
            prefer_data  <= 1'b1;
            m_awvalid    <= 1'b0;
            m_wvalid     <= 1'b0;
            m_bready     <= 1'b0;
            m_arvalid    <= 1'b0;
            m_rready     <= 1'b0;
            inst_ack_o   <= 1'b0;
            data_ack_o   <= 1'b0;
            bus_err_o    <= 1'b0;
            inst_rdata_o <= '0;
            data_rdata_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_data || grant_inst) begin
                        is_data_q   <= grant_data;
                        prefer_data <= !grant_data;
                        if (grant_data && data_we_i) begin
                            state     <= WR_AW;
                            m_awvalid <= 1'b1;
                            m_wvalid  <= 1'b1;
                        end else begin
                            state     <= RD_A;
                            m_arvalid <= 1'b1;
                        end
                    end
                end
                RD_A: begin
                    if (m_arready) begin
                        m_arvalid <= 1'b0;
                        m_rready  <= 1'b1;
                        state     <= RD_D;
                    end
                end
                RD_D: begin
                    if (m_rvalid) begin
                        m_rready  <= 1'b0;
                        bus_err_o <= (m_rresp >= 2'b10);
                        if (is_data_q) begin
                            data_rdata_o <= m_rdata;
                            data_ack_o   <= 1'b1;
                        end else begin
                            inst_rdata_o <= m_rdata;
                            inst_ack_o   <= 1'b1;
                        end
                        state <= RESP;
                    end
                end
                WR_AW: begin
                    // AW and W complete independently; a dropped valid marks its channel done
                    if (m_awvalid && m_awready) begin
                        m_awvalid <= 1'b0;
                    end
                    if (m_wvalid && m_wready) begin
                        m_wvalid <= 1'b0;
                    end
                    if ((!m_awvalid || m_awready) && (!m_wvalid || m_wready)) begin
                        m_bready <= 1'b1;
                        state    <= WR_B;
                    end
                end
                WR_B: begin
                    if (m_bvalid) begin
                        m_bready     <= 1'b0;
                        bus_err_o    <= (m_bresp >= 2'b10);
                        data_rdata_o <= '0;
                        data_ack_o   <= 1'b1;
                        state        <= RESP;
                    end
                end
                RESP: begin
                    inst_ack_o   <= 1'b0;
                    data_ack_o   <= 1'b0;
                    bus_err_o    <= 1'b0;
                    inst_rdata_o <= '0;
                    data_rdata_o <= '0;
                    state        <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
